// File: rtl/inst_buffer_param.sv
// Decoded-instruction buffer between Decode and Rename/Dispatch: compacts sparse fetch lanes
// into a circular buffer and presents a dispatch group at the head. Option: INST_BUF_PARTIAL_DISPATCH_EN.
module inst_buffer_param #(
    parameter int DEPTH     = 32,
    parameter int DEPTH_LOG = 5,
    parameter int FETCH_W   = 8,
    parameter int DISP_W    = 4,
    parameter int PKT_W     = 96,
    parameter int BR_BIT    = 80,
    localparam int DISP_W_LOG = $clog2(DISP_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       decodeReady_i,
    input  logic [FETCH_W-1:0]         decodedVector_i,
    input  logic [FETCH_W*PKT_W-1:0]   decodedPackets_i,
    output logic                       stallFetch_o,
    output logic [DISP_W-1:0]          dispValid_o,
    output logic [DISP_W*PKT_W-1:0]    dispPackets_o,
    output logic [DISP_W_LOG:0]        dispCount_o,
    output logic [DEPTH_LOG:0]         instCount_o,
    output logic [DISP_W_LOG:0]        branchCount_o
);

    logic [PKT_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] headPtr;
    logic [DEPTH_LOG-1:0] tailPtr;
    logic [DEPTH_LOG:0]   instCount;
    logic [DEPTH_LOG:0]   popAcc;
    logic [DEPTH_LOG:0]   wrCnt;
    logic [DEPTH_LOG:0]   validCnt;
    logic [DEPTH_LOG-1:0] laneOff [FETCH_W];
    logic [DISP_W_LOG:0]  dispCnt;
    logic [DISP_W_LOG:0]  brCnt;
    logic [DISP_W-1:0]    dispValid;
    logic [PKT_W-1:0]     headPkt [DISP_W];
    logic                 wr;

    assign stallFetch_o = instCount > (DEPTH_LOG+1)'(DEPTH - FETCH_W);
    assign wr           = decodeReady_i & ~stallFetch_o;

    // Each valid lane lands at tail + number of valid lanes below it, so the group is hole-free.
    always_comb begin
        popAcc = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            laneOff[i] = popAcc[DEPTH_LOG-1:0];
            popAcc     = popAcc + (DEPTH_LOG+1)'(decodedVector_i[i]);
        end
        wrCnt = wr ? popAcc : '0;
    end

    always_comb begin
`ifdef INST_BUF_PARTIAL_DISPATCH_EN
        validCnt = (instCount >= (DEPTH_LOG+1)'(DISP_W)) ? (DEPTH_LOG+1)'(DISP_W) : instCount;
`else
        validCnt = (instCount >= (DEPTH_LOG+1)'(DISP_W)) ? (DEPTH_LOG+1)'(DISP_W) : '0;
`endif
        dispCnt = stall_i ? '0 : validCnt[DISP_W_LOG:0];
    end

    always_comb begin
        brCnt         = '0;
        dispPackets_o = '0;
        for (int unsigned j = 0; j < DISP_W; j++) begin
            headPkt[j]   = mem[headPtr + DEPTH_LOG'(j)];
            dispValid[j] = (DEPTH_LOG+1)'(j) < validCnt;
            dispPackets_o[j*PKT_W +: PKT_W] = headPkt[j];
            brCnt = brCnt + (DISP_W_LOG+1)'(dispValid[j] & headPkt[j][BR_BIT]);
        end
    end

    assign dispValid_o   = dispValid;
    assign dispCount_o   = dispCnt;
    assign branchCount_o = brCnt;
    assign instCount_o   = instCount;

    always_ff @(posedge clk) begin
        if (!(reset || flush_i) && wr) begin
            for (int unsigned i = 0; i < FETCH_W; i++) begin
                if (decodedVector_i[i])
                    mem[tailPtr + laneOff[i]] <= decodedPackets_i[i*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            instCount <= '0;
        end else begin
            tailPtr   <= tailPtr + wrCnt[DEPTH_LOG-1:0];
            headPtr   <= headPtr + DEPTH_LOG'(dispCnt);
            instCount <= instCount + wrCnt - (DEPTH_LOG+1)'(dispCnt);
        end
    end

endmodule
